// File: rtl/sirv_itcm_loader.sv
// ============================================================================
// sirv_itcm_loader : streams words into an ITCM RAM, reads them back and
//                    compares sums. Revision 1.0
// ============================================================================
`default_nettype none

module sirv_itcm_loader #(
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32,
  parameter int DP = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VERIFY = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [16:0] c_DP = 17'(DP);

  state_t        state_q,   state_d;
  logic [15:0]   len_q,     len_d;
  logic [15:0]   wr_cnt_q,  wr_cnt_d;
  logic [15:0]   rd_cnt_q,  rd_cnt_d;
  logic [DW-1:0] csum_q,    csum_d;
  logic [DW-1:0] rb_sum_q,  rb_sum_d;
  logic          err_q,     err_d;
  logic          rd_pend_q, rd_pend_d;
  logic [15:0]   w_last;

  assign w_last   = len_q - 16'd1;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign checksum = csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      csum_q    <= '0;
      rb_sum_q  <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      csum_q    <= csum_d;
      rb_sum_q  <= rb_sum_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    csum_d    = csum_q;
    err_d     = err_q;
    rd_pend_d = 1'b0;
    rb_sum_d  = rb_sum_q;
    s_ready   = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_wem   = '0;
    ram_addr  = '0;
    ram_din   = '0;
    done      = 1'b0;

    // Read data returns one cycle after the read, so accumulate on the pending flag.
    if (rd_pend_q) rb_sum_d = rb_sum_q + ram_dout;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = len;
          err_d    = 1'b0;
          csum_d   = '0;
          rb_sum_d = '0;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          if (len == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, len} > c_DP) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        s_ready  = 1'b1;
        ram_cs   = s_valid;
        ram_we   = 1'b1;
        ram_wem  = '1;
        ram_addr = AW'(wr_cnt_q);
        ram_din  = s_data;
        if (s_valid) begin
          csum_d   = csum_q + s_data;
          wr_cnt_d = wr_cnt_q + 16'd1;
          if (wr_cnt_q == w_last) state_d = S_VERIFY;
        end
      end
      S_VERIFY: begin
        ram_cs    = 1'b1;
        ram_addr  = AW'(rd_cnt_q);
        rd_cnt_d  = rd_cnt_q + 16'd1;
        rd_pend_d = 1'b1;
        if (rd_cnt_q == w_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rb_sum_d != csum_q) err_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sirv_itcm_loader.sv
// ============================================================================
// tb_sirv_itcm_loader : directed self-checking bench for sirv_itcm_loader.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sirv_itcm_loader;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int AW = 32;
  localparam int DP = 512;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_ready;
  logic [15:0]   len;
  logic [DW-1:0] s_data, ram_din, ram_dout, checksum;
  logic          ram_cs, ram_we, busy, done, err;
  logic [MW-1:0] ram_wem;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  sirv_itcm_loader #(.DW(DW), .MW(MW), .AW(AW), .DP(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  // RAM model; optional corruption of address 2 on read-back
  logic [DW-1:0] mem [0:DP-1];
  logic          corrupt;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr[8:0]] <= ram_din;
    if (ram_cs && !ram_we)
      ram_dout <= mem[ram_addr[8:0]] ^ ((corrupt && ram_addr == 2) ? 32'h100 : 32'h0);
  end

  int n_checks = 0;
  int n_fail   = 0;

  int            done_cyc, nwr, nrd, rd_first, rd_last, ncs, beat;
  int            wr_cyc  [0:DP-1];
  logic [AW-1:0] wr_addr [0:DP-1];
  logic [DW-1:0] wr_data [0:DP-1];
  logic          err_c1, err_done, zero_ok;

  // Runs one load with start at cycle 0; source data is base+beat.
  task automatic run_load(input int n, input logic [DW-1:0] base, input int stall_cyc,
                          input int rst_cyc, input int restart_cyc, input int restart_len,
                          input int max_cyc);
    done_cyc = -1; nwr = 0; nrd = 0; rd_first = -1; rd_last = -1; ncs = 0; beat = 0;
    err_c1 = 1'bx; err_done = 1'bx; zero_ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      rst     = (c == rst_cyc);
      start   = (c == 0) || (c == restart_cyc);
      len     = (c == 0) ? 16'(n) : 16'(restart_len);
      s_valid = (c != stall_cyc);
      s_data  = base + DW'(beat);
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = c;
      if (done) err_done = err;
      if (c == 1) err_c1 = err;
      if (c == rst_cyc + 1)
        zero_ok = !busy && !done && !err && !s_ready && !ram_cs && !ram_we &&
                  (ram_wem == '0) && (ram_addr == '0) && (ram_din == '0) && (checksum == '0);
      if (ram_cs) ncs++;
      if (ram_cs && ram_we && nwr < DP) begin
        wr_cyc[nwr] = c; wr_addr[nwr] = ram_addr; wr_data[nwr] = ram_din; nwr++;
      end
      if (ram_cs && !ram_we) begin
        if (nrd == 0) rd_first = c;
        rd_last = c;
        nrd++;
      end
      if (s_valid && s_ready) beat++;
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 16'd4; s_valid = 1'b1; s_data = 32'h55;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err, s_ready, ram_cs, ram_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, err, s_ready, ram_cs, ram_we});
    end
    n_checks++;
    if ({ram_wem, ram_addr, ram_din, checksum} !== '0) begin
      n_fail++; $display("FAIL reset_data: got wem=%h addr=%h din=%h csum=%h expected 0", ram_wem, ram_addr, ram_din, checksum);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_prio: busy got %b expected 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_load(4, 32'h1, -1, -1, -1, 0, 40);
    n_checks++;
    if (done_cyc != 10) begin n_fail++; $display("FAIL basic_done: got %0d expected 10", done_cyc); end
    n_checks++;
    if (nwr != 4) begin n_fail++; $display("FAIL basic_nwr: got %0d expected 4", nwr); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_cyc[i] != i + 1 || wr_addr[i] !== AW'(i) || wr_data[i] !== DW'(i + 1)) begin
        n_fail++;
        $display("FAIL basic_wr%0d: got cyc=%0d addr=%0h data=%0h expected cyc=%0d addr=%0h data=%0h",
                 i, wr_cyc[i], wr_addr[i], wr_data[i], i + 1, i, i + 1);
      end
    end
    n_checks++;
    if (nrd != 4 || rd_first != 5 || rd_last != 8) begin
      n_fail++; $display("FAIL basic_rd: got n=%0d first=%0d last=%0d expected 4/5/8", nrd, rd_first, rd_last);
    end
    n_checks++;
    if (checksum !== 32'hA || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_sum: got csum=%h err=%b expected 0000000a/0", checksum, err);
    end
  endtask

  task automatic test_stall();
    run_load(3, 32'h10, 2, -1, -1, 0, 40);
    n_checks++;
    if (done_cyc != 9) begin n_fail++; $display("FAIL stall_done: got %0d expected 9", done_cyc); end
    n_checks++;
    if (nwr != 3 || wr_cyc[0] != 1 || wr_cyc[1] != 3 || wr_cyc[2] != 4) begin
      n_fail++; $display("FAIL stall_wrcyc: got n=%0d cyc=%0d,%0d,%0d expected 3 writes at 1,3,4",
                         nwr, wr_cyc[0], wr_cyc[1], wr_cyc[2]);
    end
    n_checks++;
    if (wr_addr[0] !== 0 || wr_addr[1] !== 1 || wr_addr[2] !== 2 || wr_data[1] !== 32'h11) begin
      n_fail++; $display("FAIL stall_addr: got %0h,%0h,%0h d1=%h expected 0,1,2 d1=11",
                         wr_addr[0], wr_addr[1], wr_addr[2], wr_data[1]);
    end
    n_checks++;
    if (checksum !== 32'h33 || err !== 1'b0) begin
      n_fail++; $display("FAIL stall_sum: got csum=%h err=%b expected 00000033/0", checksum, err);
    end
  endtask

  task automatic test_len_limits();
    run_load(0, 32'h1, -1, -1, -1, 0, 10);
    n_checks++;
    if (done_cyc != 1 || ncs != 0 || checksum !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL len0: got done=%0d cs=%0d csum=%h err=%b expected 1/0/0/0", done_cyc, ncs, checksum, err);
    end
    run_load(513, 32'h1, -1, -1, -1, 0, 10);
    n_checks++;
    if (done_cyc != 1 || ncs != 0 || err !== 1'b1) begin
      n_fail++; $display("FAIL len_over: got done=%0d cs=%0d err=%b expected 1/0/1", done_cyc, ncs, err);
    end
    run_load(DP, 32'h1, -1, -1, -1, 0, 1100);
    n_checks++;
    if (done_cyc != 1026 || nwr != DP || wr_addr[DP-1] !== AW'(DP - 1)) begin
      n_fail++; $display("FAIL len_dp: got done=%0d nwr=%0d last=%0h expected 1026/512/1ff", done_cyc, nwr, wr_addr[DP-1]);
    end
    n_checks++;
    if (checksum !== 32'h20100 || err !== 1'b0) begin
      n_fail++; $display("FAIL len_dp_sum: got csum=%h err=%b expected 00020100/0", checksum, err);
    end
  endtask

  task automatic test_corrupt();
    corrupt = 1'b1;
    run_load(4, 32'h1, -1, -1, -1, 0, 40);
    corrupt = 1'b0;
    n_checks++;
    if (done_cyc != 10 || err_done !== 1'b1) begin
      n_fail++; $display("FAIL corrupt: got done=%0d err=%b expected 10/1", done_cyc, err_done);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL corrupt_sticky: got %b expected 1", err); end
    run_load(1, 32'h7, -1, -1, -1, 0, 20);
    n_checks++;
    if (err_c1 !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL corrupt_clear: got c1=%b end=%b expected 0/0", err_c1, err);
    end
  endtask

  task automatic test_reset_verify();
    run_load(4, 32'h1, -1, 6, -1, 0, 20);
    n_checks++;
    if (zero_ok !== 1'b1) begin n_fail++; $display("FAIL rstv_zero: got %b expected 1", zero_ok); end
    n_checks++;
    if (done_cyc != -1) begin n_fail++; $display("FAIL rstv_nodone: got %0d expected -1", done_cyc); end
    run_load(1, 32'hFFFFFFFF, -1, -1, -1, 0, 20);
    n_checks++;
    if (done_cyc != 4 || checksum !== 32'hFFFFFFFF || err !== 1'b0) begin
      n_fail++; $display("FAIL rstv_reload: got done=%0d csum=%h err=%b expected 4/ffffffff/0", done_cyc, checksum, err);
    end
  endtask

  task automatic test_restart_ignored();
    run_load(4, 32'h1, -1, -1, 2, 2, 40);
    n_checks++;
    if (done_cyc != 10 || nwr != 4 || nrd != 4) begin
      n_fail++; $display("FAIL restart: got done=%0d nwr=%0d nrd=%0d expected 10/4/4", done_cyc, nwr, nrd);
    end
    n_checks++;
    if (checksum !== 32'hA || err !== 1'b0) begin
      n_fail++; $display("FAIL restart_sum: got csum=%h err=%b expected 0000000a/0", checksum, err);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0; corrupt = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_len_limits();
    test_corrupt();
    test_reset_verify();
    test_restart_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sirv_itcm_loader.md
SIRV_ITCM_LOADER -- requirements
Module: sirv_itcm_loader

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DW, 32, RAM data width.
REQ-002 MW, 4, RAM byte-mask width (DW/8).
REQ-003 AW, 32, RAM word-address width.
REQ-004 DP, 512, RAM depth in words; upper bound on the load length.
REQ-005 The block SHALL have these ports (name, direction, width, meaning): clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse to begin a load; ignored unless in IDLE.
REQ-008 len  in  16  number of words to load; sampled when start is accepted.
REQ-009 s_valid  in  1  source word valid.
REQ-010 s_ready  out  1  block accepts a word; a beat transfers when s_valid & s_ready.
REQ-011 s_data  in  DW  source word.
REQ-012 ram_cs  out  1  RAM chip select.
REQ-013 ram_we  out  1  RAM write enable (1 = write, 0 = read).
REQ-014 ram_wem  out  MW  RAM byte write mask.
REQ-015 ram_addr  out  AW  RAM word address.
REQ-016 ram_din  out  DW  RAM write data.
REQ-017 ram_dout  in  DW  RAM read data, valid the cycle after a read (cs=1, we=0).
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 err  out  1  sticky error flag, cleared on the next accepted start.
REQ-021 checksum  out  DW  sum mod 2^DW of all written words, held until the next accepted start.

Function
REQ-022 The FSM SHALL have states IDLE, WRITE, VERIFY, DRAIN and DONE.
REQ-023 IDLE on start: latch len, clear err, checksum and counters, then go to:
- DONE when len=0;
- DONE with err=1 when len>DP, with no RAM access;
- WRITE otherwise.
REQ-024 In WRITE, s_ready SHALL be 1 and, combinationally in the same cycle:
- ram_cs = s_valid;
- ram_we = 1;
- ram_wem = all ones;
- ram_addr = wr_cnt;
- ram_din = s_data.
REQ-025 Each WRITE beat SHALL add s_data to checksum (mod 2^DW) and increment wr_cnt.
REQ-026 WRITE SHALL go to VERIFY on the beat where wr_cnt = len-1.
REQ-027 An s_valid gap SHALL stall WRITE with ram_cs=0, leaving wr_cnt and checksum unchanged.
REQ-028 In VERIFY, the block SHALL issue one read per cycle: ram_cs=1, ram_we=0, ram_wem=0, ram_addr=rd_cnt, with rd_cnt incrementing from 0.
REQ-029 After the read with rd_cnt = len-1, VERIFY SHALL go to DRAIN.
REQ-030 A registered read-pending flag SHALL add ram_dout to rb_sum in the cycle after each read, including the DRAIN cycle.
REQ-031 DRAIN SHALL last exactly one cycle, with ram_cs=0.
REQ-032 On DRAIN exit, err SHALL be set if rb_sum != checksum; the FSM then goes to DONE.
REQ-033 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-034 Outside WRITE and VERIFY, ram_cs, ram_we, ram_wem and s_ready SHALL be 0.
REQ-035 Latency with len=N≥1 and s_valid held high, start at cycle 0:
- writes occur in cycles 1..N;
- reads occur in cycles N+1..2N;
- DRAIN is cycle 2N+1;
- done is at cycle 2N+2.
REQ-036 With len=0 or len>DP, done SHALL be at cycle 1.
REQ-037 start asserted while busy SHALL be ignored, with no effect on len, counters or err.
REQ-038 Counters SHALL be 16 bits; ram_addr SHALL be the counter zero-extended to AW; len=DP SHALL be legal and SHALL write addresses 0..DP-1 with no wrap.
REQ-039 s_data presented outside WRITE SHALL not be consumed.

Reset
REQ-040 rst high at a clock edge SHALL force IDLE at that edge.
REQ-041 That reset edge SHALL zero busy, done, err, checksum, rb_sum, counters, s_ready, ram_cs, ram_we, ram_wem, ram_addr and ram_din.
REQ-042 Reset mid-WRITE or mid-VERIFY SHALL abort with no done pulse; RAM contents already written are not restored.
REQ-043 rst SHALL take priority over a simultaneous start.

Verification
REQ-044 len=4, s_valid always 1, words 0x1,0x2,0x3,0x4 -> RAM addr 0..3 written in cycles 1..4, reads in cycles 5..8, done at cycle 10, checksum=0xA, err=0.
REQ-045 len=3 with s_valid low in cycle 2 -> three writes at addr 0,1,2 with no write in the stall cycle; done 1 cycle later than the no-stall case; err=0.
REQ-046 len=0 -> no ram_cs, done at cycle 1, checksum=0, err=0; len=513 with DP=512 -> no ram_cs, done at cycle 1, err=1.
REQ-047 RAM model corrupts addr 2 on read-back (len=4) -> done at cycle 10 with err=1; err SHALL remain 1 until the next start, then clear.
REQ-048 rst pulsed during VERIFY -> next cycle all outputs 0, no done pulse; a new start with len=1, word 0xFFFFFFFF -> done at cycle 4, checksum=0xFFFFFFFF.
REQ-049 start pulsed again during WRITE with a different len -> ignored; the original load completes with the original len.
